// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, sequencer states and default
// multi-cycle latencies.
package cpu_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;
    localparam logic [4:0] OP_INCPC = 5'b11010;
    localparam logic [4:0] OP_HALT  = 5'b11011;

    localparam int MUL_CYC_DEF = 4;
    localparam int DIV_CYC_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE,
        S_HALT
    } seq_state_e;

    // Counter preload (N-1) for an execute-side opcode
    function automatic logic [3:0] exec_last(
        input logic [4:0] op,
        input int         mul_cyc,
        input int         div_cyc
    );
        logic [3:0] r;
        r = 4'd0;
        if (op == OP_MUL) begin
            r = 4'(mul_cyc - 1);
        end else if (op == OP_DIV) begin
            r = 4'(div_cyc - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the PC requester,
// bit 1 the execute requester.
module alu_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0: PC side wins a tie, 1: execute side wins a tie
    logic rr_q;

    always_comb begin
        gnt = 2'b00;
        case ({reset, req})
            3'b001:  gnt = 2'b01;
            3'b010:  gnt = 2'b10;
            3'b011:  gnt = rr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (gnt[0]) begin
            rr_q <= 1'b1;
        end else if (gnt[1]) begin
            rr_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// ALU sequencer: arbitrates PC-increment and execute requests, drives
// the sibling ALU and captures its result after a per-opcode latency.
module alu_seq
    import cpu_pkg::*;
#(
    parameter int MUL_CYC = MUL_CYC_DEF,
    parameter int DIV_CYC = DIV_CYC_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_req,
    input  logic [31:0] pc_val,
    output logic        pc_gnt,
    input  logic        ex_req,
    input  logic [4:0]  ex_opcode,
    input  logic [31:0] ex_y,
    input  logic [31:0] ex_b,
    input  logic        ex_br,
    output logic        ex_gnt,
    output logic        alu_IncPC,
    output logic        alu_br_flag,
    output logic [31:0] alu_Y,
    output logic [31:0] alu_B,
    output logic [4:0]  alu_opcode,
    input  logic [31:0] alu_HI,
    input  logic [31:0] alu_LO,
    output logic [31:0] ZHI,
    output logic [31:0] ZLO,
    output logic        done,
    output logic        done_src,
    output logic        busy,
    output logic        halted
);

    seq_state_e  state_q;
    logic [3:0]  cnt_q;
    logic        incpc_q;
    logic        br_q;
    logic [31:0] y_q;
    logic [31:0] b_q;
    logic [4:0]  op_q;
    logic [31:0] zhi_q;
    logic [31:0] zlo_q;
    logic        src_q;
    logic [1:0]  arb_req;
    logic [1:0]  gnt;

    assign arb_req = {ex_req, pc_req} & {2{state_q == S_IDLE}};

    alu_rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   (arb_req),
        .gnt   (gnt)
    );

    assign pc_gnt      = gnt[0];
    assign ex_gnt      = gnt[1];
    assign alu_IncPC   = incpc_q;
    assign alu_br_flag = br_q;
    assign alu_Y       = y_q;
    assign alu_B       = b_q;
    assign alu_opcode  = op_q;
    assign ZHI         = zhi_q;
    assign ZLO         = zlo_q;
    assign done        = (state_q == S_DONE);
    assign done_src    = src_q & (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign halted      = (state_q == S_HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            incpc_q <= 1'b0;
            br_q    <= 1'b0;
            y_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 5'd0;
            zhi_q   <= 32'd0;
            zlo_q   <= 32'd0;
            src_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt[0]) begin
                        incpc_q <= 1'b1;
                        br_q    <= 1'b0;
                        y_q     <= 32'd0;
                        b_q     <= pc_val;
                        op_q    <= OP_INCPC;
                        src_q   <= 1'b1;
                        cnt_q   <= 4'd0;
                        state_q <= S_EXEC;
                    end else if (gnt[1]) begin
                        incpc_q <= 1'b0;
                        br_q    <= ex_br;
                        y_q     <= ex_y;
                        b_q     <= ex_b;
                        op_q    <= ex_opcode;
                        src_q   <= 1'b0;
                        if (ex_opcode == OP_HALT) begin
                            cnt_q   <= 4'd0;
                            state_q <= S_HALT;
                        end else begin
                            cnt_q   <= exec_last(ex_opcode, MUL_CYC, DIV_CYC);
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        zhi_q   <= alu_HI;
                        zlo_q   <= alu_LO;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural model of the sibling ALU.
module tb_alu_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        pc_req;
    logic [31:0] pc_val;
    logic        pc_gnt;
    logic        ex_req;
    logic [4:0]  ex_opcode;
    logic [31:0] ex_y;
    logic [31:0] ex_b;
    logic        ex_br;
    logic        ex_gnt;
    logic        alu_IncPC;
    logic        alu_br_flag;
    logic [31:0] alu_Y;
    logic [31:0] alu_B;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_HI;
    logic [31:0] alu_LO;
    logic [31:0] ZHI;
    logic [31:0] ZLO;
    logic        done;
    logic        done_src;
    logic        busy;
    logic        halted;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    alu_seq dut (
        .clock       (clock),
        .reset       (reset),
        .pc_req      (pc_req),
        .pc_val      (pc_val),
        .pc_gnt      (pc_gnt),
        .ex_req      (ex_req),
        .ex_opcode   (ex_opcode),
        .ex_y        (ex_y),
        .ex_b        (ex_b),
        .ex_br       (ex_br),
        .ex_gnt      (ex_gnt),
        .alu_IncPC   (alu_IncPC),
        .alu_br_flag (alu_br_flag),
        .alu_Y       (alu_Y),
        .alu_B       (alu_B),
        .alu_opcode  (alu_opcode),
        .alu_HI      (alu_HI),
        .alu_LO      (alu_LO),
        .ZHI         (ZHI),
        .ZLO         (ZLO),
        .done        (done),
        .done_src    (done_src),
        .busy        (busy),
        .halted      (halted)
    );

    // Sibling ALU model
    always_comb begin
        logic [63:0] p;
        p      = 64'd0;
        alu_HI = 32'd0;
        alu_LO = 32'd0;
        case (alu_opcode)
            5'b00011: alu_LO = alu_Y + alu_B;
            5'b01111: begin
                p      = {32'd0, alu_Y} * {32'd0, alu_B};
                alu_HI = p[63:32];
                alu_LO = p[31:0];
            end
            5'b10000: begin
                if (alu_B != 32'd0) begin
                    alu_LO = alu_Y / alu_B;
                    alu_HI = alu_Y % alu_B;
                end
            end
            5'b11010: alu_LO = alu_B + 32'd1;
            default: begin
                alu_HI = 32'd0;
                alu_LO = 32'd0;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        pc_req    = 1'b0;
        pc_val    = 32'd0;
        ex_req    = 1'b0;
        ex_opcode = 5'd0;
        ex_y      = 32'd0;
        ex_b      = 32'd0;
        ex_br     = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_zlo", 64'(ZLO), 64'd0);
        chk("rst_op", 64'(alu_opcode), 64'd0);

        // Reset high suppresses grants
        ex_req = 1'b1;
        #1;
        chk("rst_nogrant", 64'({pc_gnt, ex_gnt}), 64'd0);

        // _add 5 + 7
        reset     = 1'b0;
        ex_opcode = 5'b00011;
        ex_y      = 32'd5;
        ex_b      = 32'd7;
        #1;
        chk("add_gnt", 64'({pc_gnt, ex_gnt}), 64'b01);
        tick();
        ex_req = 1'b0;
        chk("add_op_c1", 64'(alu_opcode), 64'b00011);
        chk("add_busy_c1", 64'(busy), 64'd1);
        chk("add_done_c1", 64'(done), 64'd0);
        tick();
        chk("add_done_c2", 64'(done), 64'd1);
        chk("add_src", 64'(done_src), 64'd0);
        chk("add_zlo", 64'(ZLO), 64'd12);
        chk("add_zhi", 64'(ZHI), 64'd0);
        tick();
        chk("add_done_c3", 64'(done), 64'd0);
        chk("add_idle", 64'(busy), 64'd0);
        chk("add_zlo_hold", 64'(ZLO), 64'd12);
        chk("add_op_hold", 64'(alu_opcode), 64'b00011);

        // _mul 0x10000 * 0x10000, four EXEC cycles
        ex_req    = 1'b1;
        ex_opcode = 5'b01111;
        ex_y      = 32'h10000;
        ex_b      = 32'h10000;
        #1;
        chk("mul_gnt", 64'(ex_gnt), 64'd1);
        tick();
        ex_req = 1'b0;
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("mul_nodone_c%0d", i), 64'(done), 64'd0);
            tick();
        end
        chk("mul_done_c5", 64'(done), 64'd1);
        chk("mul_zhi", 64'(ZHI), 64'd1);
        chk("mul_zlo", 64'(ZLO), 64'd0);
        tick();

        // Both requesters held: pc, ex, pc
        pc_req    = 1'b1;
        pc_val    = 32'h20;
        ex_req    = 1'b1;
        ex_opcode = 5'b00011;
        ex_y      = 32'd1;
        ex_b      = 32'd2;
        #1;
        chk("rr_g1", 64'({pc_gnt, ex_gnt}), 64'b10);
        tick();
        chk("rr_exec_nogrant", 64'({pc_gnt, ex_gnt}), 64'b00);
        chk("rr_incpc", 64'(alu_IncPC), 64'd1);
        chk("rr_pcop", 64'(alu_opcode), 64'b11010);
        tick();
        chk("rr_pc_done", 64'(done), 64'd1);
        chk("rr_pc_src", 64'(done_src), 64'd1);
        chk("rr_pc_zlo", 64'(ZLO), 64'h21);
        chk("rr_done_nogrant", 64'({pc_gnt, ex_gnt}), 64'b00);
        tick();
        chk("rr_g2", 64'({pc_gnt, ex_gnt}), 64'b01);
        tick();
        tick();
        chk("rr_ex_done", 64'(done), 64'd1);
        chk("rr_ex_src", 64'(done_src), 64'd0);
        chk("rr_ex_zlo", 64'(ZLO), 64'd3);
        tick();
        chk("rr_g3", 64'({pc_gnt, ex_gnt}), 64'b10);
        tick();
        pc_req = 1'b0;
        ex_req = 1'b0;
        tick();
        tick();

        // _div with reset during EXEC cycle 3
        ex_req    = 1'b1;
        ex_opcode = 5'b10000;
        ex_y      = 32'd100;
        ex_b      = 32'd7;
        #1;
        chk("div_gnt", 64'(ex_gnt), 64'd1);
        tick();
        ex_req = 1'b0;
        tick();
        tick();
        chk("div_busy_c3", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("div_rst_busy", 64'(busy), 64'd0);
        chk("div_rst_zlo", 64'(ZLO), 64'd0);
        chk("div_rst_done", 64'(done), 64'd0);
        chk("div_rst_op", 64'(alu_opcode), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("div_no_done", 64'(done), 64'd0);
        end

        // _halt, then PC requests ignored until reset
        ex_req    = 1'b1;
        ex_opcode = 5'b11011;
        #1;
        chk("halt_gnt", 64'(ex_gnt), 64'd1);
        tick();
        ex_req = 1'b0;
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_busy", 64'(busy), 64'd1);
        pc_req = 1'b1;
        pc_val = 32'h40;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("halt_no_pcgnt", 64'(pc_gnt), 64'd0);
            chk("halt_no_done", 64'(done), 64'd0);
            tick();
        end
        reset = 1'b1;
        #1;
        chk("halt_rst_nogrant", 64'(pc_gnt), 64'd0);
        tick();
        reset = 1'b0;
        chk("halt_rst_halted", 64'(halted), 64'd0);
        chk("halt_rst_busy", 64'(busy), 64'd0);
        #1;
        chk("post_rst_pcgnt", 64'({pc_gnt, ex_gnt}), 64'b10);
        tick();
        pc_req = 1'b0;
        tick();
        chk("post_rst_done", 64'(done), 64'd1);
        chk("post_rst_src", 64'(done_src), 64'd1);
        chk("post_rst_zlo", 64'(ZLO), 64'h41);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
